// File: rtl/tns_decoder_22_pkg.sv
// Shared TNS constants: data width, codeword width and the per-bit weights
// used by the 22-bit TNS decoder and its group adders.
package tns_decoder_22_pkg;

  localparam int unsigned BLEN08_C   = 32'd16;
  localparam int unsigned TNS_CODE_W = 32'd22;
  localparam int unsigned TNS_SUM_W  = BLEN08_C + 32'd1;

  // Weights form a complete sequence, so every value up to their total can be encoded
  localparam int unsigned TNS01_A = 32'd3;
  localparam int unsigned TNS01_B = 32'd2;
  localparam int unsigned TNS01_C = 32'd1;
  localparam int unsigned TNS02_A = 32'd13;
  localparam int unsigned TNS02_B = 32'd8;
  localparam int unsigned TNS02_C = 32'd5;
  localparam int unsigned TNS03_A = 32'd55;
  localparam int unsigned TNS03_B = 32'd34;
  localparam int unsigned TNS03_C = 32'd21;
  localparam int unsigned TNS04_A = 32'd233;
  localparam int unsigned TNS04_B = 32'd144;
  localparam int unsigned TNS04_C = 32'd89;
  localparam int unsigned TNS05_A = 32'd987;
  localparam int unsigned TNS05_B = 32'd610;
  localparam int unsigned TNS05_C = 32'd377;
  localparam int unsigned TNS06_A = 32'd4181;
  localparam int unsigned TNS06_B = 32'd2584;
  localparam int unsigned TNS06_C = 32'd1597;
  localparam int unsigned TNS07_A = 32'd17711;
  localparam int unsigned TNS07_B = 32'd10946;
  localparam int unsigned TNS07_C = 32'd6765;
  localparam int unsigned TNS08_C = 32'd28657;

  typedef logic [TNS_SUM_W-1:0] tns_sum_t;

endpackage

// File: rtl/tns_group_sum.sv
// Registered weighted sum of one 3-bit TNS group; loads only when its
// pipeline stage advances with valid data.
module tns_group_sum
  import tns_decoder_22_pkg::*;
#(
  parameter int unsigned SUM_W = TNS_SUM_W,
  parameter int unsigned WA    = 32'd1,
  parameter int unsigned WB    = 32'd1,
  parameter int unsigned WC    = 32'd1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       bits,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] sum_s;
  logic [SUM_W-1:0] sum_r;

  // Combinational weighted sum of the three group bits
  always_comb begin
    sum_s = (bits[2] ? SUM_W'(WA) : {SUM_W{1'b0}})
          + (bits[1] ? SUM_W'(WB) : {SUM_W{1'b0}})
          + (bits[0] ? SUM_W'(WC) : {SUM_W{1'b0}});
  end

  // Partial-sum register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_r <= {SUM_W{1'b0}};
    end else if (load) begin
      sum_r <= sum_s;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/tns_decoder_22.sv
// 22-bit TNS codeword decoder: three-stage valid/ready pipeline that rebuilds
// the data word as the weighted sum of the codeword bits and flags overflow.
module tns_decoder_22
  import tns_decoder_22_pkg::*;
#(
  parameter int unsigned DATA_W = BLEN08_C,
  parameter int unsigned CODE_W = TNS_CODE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned SUM_W = DATA_W + 32'd1;

  logic              v1_r, v2_r, v3_r;
  logic              ld1_s, ld2_s, ld3_s;
  logic [CODE_W-1:0] code_r;
  logic [SUM_W-1:0]  p21_r;
  logic [SUM_W-1:0]  grp_s [7];
  logic [SUM_W-1:0]  sum_s;
  logic [DATA_W-1:0] dataout_r;
  logic              out_err_r;

  // Stage enables: a stage loads when it is empty or its successor moves on
  always_comb begin
    ld3_s = !v3_r || out_ready;
    ld2_s = !v2_r || ld3_s;
    ld1_s = !v1_r || ld2_s;
  end

  assign in_ready = ld1_s;

  // S1: codeword capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_r   <= 1'b0;
      code_r <= {CODE_W{1'b0}};
    end else begin
      if (ld1_s) v1_r <= in_valid;
      if (ld1_s && in_valid) code_r <= code_in;
    end
  end

  // S2: valid flag and the lone bit-21 term
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_r  <= 1'b0;
      p21_r <= {SUM_W{1'b0}};
    end else begin
      if (ld2_s) v2_r <= v1_r;
      if (ld2_s && v1_r) p21_r <= code_r[21] ? SUM_W'(TNS08_C) : {SUM_W{1'b0}};
    end
  end

  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS07_A), .WB(TNS07_B), .WC(TNS07_C)) u_grp7 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[20:18]), .sum(grp_s[6]));
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS06_A), .WB(TNS06_B), .WC(TNS06_C)) u_grp6 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[17:15]), .sum(grp_s[5]));
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS05_A), .WB(TNS05_B), .WC(TNS05_C)) u_grp5 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[14:12]), .sum(grp_s[4]));
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS04_A), .WB(TNS04_B), .WC(TNS04_C)) u_grp4 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[11:9]), .sum(grp_s[3]));
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS03_A), .WB(TNS03_B), .WC(TNS03_C)) u_grp3 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[8:6]), .sum(grp_s[2]));
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS02_A), .WB(TNS02_B), .WC(TNS02_C)) u_grp2 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[5:3]), .sum(grp_s[1]));
  // Bit 0 carries unit weight; TNS01_C has no role in the decoded value
  tns_group_sum #(.SUM_W(SUM_W), .WA(TNS01_A), .WB(TNS01_B), .WC(32'd1)) u_grp1 (
    .clock(clock), .reset(reset), .load(ld2_s && v1_r), .bits(code_r[2:0]), .sum(grp_s[0]));

  // S3 adder tree over the eight partial sums
  always_comb begin
    sum_s = ((p21_r + grp_s[6]) + (grp_s[5] + grp_s[4]))
          + ((grp_s[3] + grp_s[2]) + (grp_s[1] + grp_s[0]));
  end

  // S3: output register, held while downstream stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_r      <= 1'b0;
      dataout_r <= {DATA_W{1'b0}};
      out_err_r <= 1'b0;
    end else begin
      if (ld3_s) v3_r <= v2_r;
      if (ld3_s && v2_r) begin
        dataout_r <= sum_s[DATA_W-1:0];
        out_err_r <= sum_s[DATA_W];
      end
    end
  end

  assign dataout   = dataout_r;
  assign out_err   = out_err_r;
  assign out_valid = v3_r;

endmodule
